i2c_reg_sequencer: RTL and testbench

//  Executes complete I2C register transactions (single-byte write or single-byte read)
//  by sequencing i2c_master's cmd/dat/ws interface.

---
 rtl/i2c_reg_sequencer_pkg.sv | 36 +++
 rtl/i2c_seq_step_rom.sv | 67 ++++++
 rtl/i2c_reg_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_reg_sequencer_pkg.sv
// i2c_reg_sequencer_pkg
//   Shared constants for the I2C register sequencer: i2c_master command bits
//   (C_*), status bit positions (SB_*), sequencer state encodings (SEQ_*) and
//   step-count constants for the write and read command sequences.
//   No ports (package).
package i2c_reg_sequencer_pkg;

    // i2c_master command word: one-hot-ish bits that may be OR-ed together.
    localparam int C_SZ = 6;
    localparam logic [C_SZ-1:0] C_STRT = 6'b000001;
    localparam logic [C_SZ-1:0] C_STOP = 6'b000010;
    localparam logic [C_SZ-1:0] C_WRTE = 6'b000100;
    localparam logic [C_SZ-1:0] C_READ = 6'b001000;
    localparam logic [C_SZ-1:0] C_NACK = 6'b010000;
    localparam logic [C_SZ-1:0] C_CLRS = 6'b100000;

    // i2c_master status word: only BSY and ERR exist on this interface.
    localparam int S_SZ   = 2;
    localparam int SB_ERR = 0;
    localparam int SB_BSY = 1;

    // Step indices within one register transaction.
    localparam logic [2:0] WR_LAST_STEP = 3'd2;
    localparam logic [2:0] RD_READ_STEP = 3'd3;
    localparam logic [2:0] RD_LAST_STEP = 3'd4;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_ISSUE     = 3'd1,
        SEQ_WAIT_RISE = 3'd2,
        SEQ_WAIT_FALL = 3'd3,
        SEQ_CLR       = 3'd4,
        SEQ_DONE      = 3'd5
    } seq_state_e;

endpackage

// File: rtl/i2c_seq_step_rom.sv
// i2c_seq_step_rom
//   Combinational table giving the i2c_master command and data byte for each
//   step of a single-byte register write or read, plus a flag marking the
//   final step of the transaction.
//   Ports: rd_i (1=read), step_i (step index), dev_i (7-bit address),
//          reg_i (register index), wdat_i (write data)
//          -> cmd_o (master command), dat_o (master data), last_o (final step)
module i2c_seq_step_rom
    import i2c_reg_sequencer_pkg::*;
(
    input  logic            rd_i,
    input  logic [2:0]      step_i,
    input  logic [6:0]      dev_i,
    input  logic [7:0]      reg_i,
    input  logic [7:0]      wdat_i,
    output logic [C_SZ-1:0] cmd_o,
    output logic [7:0]      dat_o,
    output logic            last_o
);

    // Step decode; indices past the last step fall back to a harmless STOP.
    always_comb begin
        cmd_o  = C_STOP;
        dat_o  = 8'h00;
        last_o = 1'b1;
        case (step_i)
            3'd0: begin
                cmd_o  = C_STRT | C_WRTE;
                dat_o  = {dev_i, 1'b0};
                last_o = 1'b0;
            end
            3'd1: begin
                cmd_o  = C_WRTE;
                dat_o  = reg_i;
                last_o = 1'b0;
            end
            3'd2: begin
                if (rd_i) begin
                    // Repeated start with the read bit set.
                    cmd_o  = C_STRT | C_WRTE;
                    dat_o  = {dev_i, 1'b1};
                    last_o = 1'b0;
                end else begin
                    cmd_o  = C_WRTE | C_STOP;
                    dat_o  = wdat_i;
                    last_o = 1'b1;
                end
            end
            3'd3: begin
                cmd_o  = C_READ | C_NACK;
                dat_o  = 8'h00;
                last_o = 1'b0;
            end
            3'd4: begin
                cmd_o  = C_STOP;
                dat_o  = 8'h00;
                last_o = 1'b1;
            end
            default: begin
                cmd_o  = C_STOP;
                dat_o  = 8'h00;
                last_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer
//   Runs complete single-byte I2C register writes/reads by sequencing the
//   cmd/dat/ws interface of i2c_master. On a master error or timeout it
//   issues C_CLRS followed by a recovery C_STOP and reports rsp_err_o.
//   Ports: clk_i, rst_ni (async active-low)
//          req_valid_i/req_ready_o, req_rd_i, req_dev_i, req_reg_i, req_wdat_i
//          rsp_valid_o (1-cycle pulse), rsp_err_o, rsp_rdat_o
//          mst_cmd_o, mst_dat_o, mst_ws_o (strobe) to i2c_master
//          mst_stat_i (BSY/ERR), mst_rdat_i from i2c_master
module i2c_reg_sequencer
    import i2c_reg_sequencer_pkg::*;
#(
    parameter int RISE_TMO = 16,
    parameter int BUSY_TMO = 65535
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_rd_i,
    input  logic [6:0]      req_dev_i,
    input  logic [7:0]      req_reg_i,
    input  logic [7:0]      req_wdat_i,
    output logic            rsp_valid_o,
    output logic            rsp_err_o,
    output logic [7:0]      rsp_rdat_o,
    output logic [C_SZ-1:0] mst_cmd_o,
    output logic [7:0]      mst_dat_o,
    output logic            mst_ws_o,
    input  logic [S_SZ-1:0] mst_stat_i,
    input  logic [7:0]      mst_rdat_i
);

    localparam int TMO_MAX = (RISE_TMO > BUSY_TMO) ? RISE_TMO : BUSY_TMO;
    localparam int CW      = $clog2(TMO_MAX + 1);

    seq_state_e      state_q;
    logic            req_ready_q, rsp_valid_q, rsp_err_q, mst_ws_q;
    logic [7:0]      rsp_rdat_q, mst_dat_q;
    logic [C_SZ-1:0] mst_cmd_q;
    logic            rd_q, last_q, err_q, rec_q;
    logic [6:0]      dev_q;
    logic [7:0]      reg_q, wdat_q;
    logic [2:0]      step_q, step_d;
    logic [CW-1:0]   cnt_q;

    logic            sel_rd_s;
    logic [6:0]      sel_dev_s;
    logic [7:0]      sel_reg_s, sel_wdat_s;
    logic [C_SZ-1:0] rom_cmd_s;
    logic [7:0]      rom_dat_s;
    logic            rom_last_s;
    logic            bsy_s, err_s, fault_s;

    assign bsy_s = mst_stat_i[SB_BSY];
    assign err_s = mst_stat_i[SB_ERR];

    // ROM is fed with the live request in IDLE so the first strobe can leave
    // on the accept edge; afterwards it looks one step ahead of step_q.
    always_comb begin
        if (state_q == SEQ_IDLE) begin
            sel_rd_s   = req_rd_i;
            sel_dev_s  = req_dev_i;
            sel_reg_s  = req_reg_i;
            sel_wdat_s = req_wdat_i;
            step_d     = 3'd0;
        end else begin
            sel_rd_s   = rd_q;
            sel_dev_s  = dev_q;
            sel_reg_s  = reg_q;
            sel_wdat_s = wdat_q;
            step_d     = step_q + 3'd1;
        end
    end

    i2c_seq_step_rom u_rom (
        .rd_i   (sel_rd_s),
        .step_i (step_d),
        .dev_i  (sel_dev_s),
        .reg_i  (sel_reg_s),
        .wdat_i (sel_wdat_s),
        .cmd_o  (rom_cmd_s),
        .dat_o  (rom_dat_s),
        .last_o (rom_last_s)
    );

    // Error/timeout detection while waiting on the master; ERR always wins.
    always_comb begin
        fault_s = 1'b0;
        case (state_q)
            SEQ_WAIT_RISE: fault_s = err_s || (!bsy_s && (cnt_q >= CW'(RISE_TMO - 1)));
            SEQ_WAIT_FALL: fault_s = err_s || (bsy_s && (cnt_q >= CW'(BUSY_TMO - 1)));
            default:       fault_s = 1'b0;
        endcase
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SEQ_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdat_q  <= 8'h00;
            mst_cmd_q   <= '0;
            mst_dat_q   <= 8'h00;
            mst_ws_q    <= 1'b0;
            rd_q        <= 1'b0;
            dev_q       <= 7'h00;
            reg_q       <= 8'h00;
            wdat_q      <= 8'h00;
            step_q      <= 3'd0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            rec_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            mst_ws_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            if (fault_s) begin
                if (rec_q) begin
                    // A failing recovery STOP ends the transaction, no retry.
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    state_q     <= SEQ_DONE;
                end else begin
                    mst_cmd_q <= C_CLRS;
                    mst_dat_q <= 8'h00;
                    mst_ws_q  <= 1'b1;
                    err_q     <= 1'b1;
                    rec_q     <= 1'b1;
                    state_q   <= SEQ_CLR;
                end
            end else begin
                case (state_q)
                    SEQ_IDLE: begin
                        if (req_valid_i && req_ready_q) begin
                            req_ready_q <= 1'b0;
                            rd_q        <= req_rd_i;
                            dev_q       <= req_dev_i;
                            reg_q       <= req_reg_i;
                            wdat_q      <= req_wdat_i;
                            step_q      <= step_d;
                            last_q      <= rom_last_s;
                            err_q       <= 1'b0;
                            rec_q       <= 1'b0;
                            mst_cmd_q   <= rom_cmd_s;
                            mst_dat_q   <= rom_dat_s;
                            mst_ws_q    <= 1'b1;
                            state_q     <= SEQ_ISSUE;
                        end else begin
                            req_ready_q <= 1'b1;
                        end
                    end
                    SEQ_ISSUE: begin
                        cnt_q   <= '0;
                        state_q <= SEQ_WAIT_RISE;
                    end
                    SEQ_WAIT_RISE: begin
                        if (bsy_s) begin
                            // Restart so the busy limit counts BSY-high cycles only.
                            cnt_q   <= '0;
                            state_q <= SEQ_WAIT_FALL;
                        end else if (cnt_q != '1) begin
                            cnt_q <= cnt_q + CW'(1);
                        end else begin
                            cnt_q <= cnt_q;
                        end
                    end
                    SEQ_WAIT_FALL: begin
                        if (!bsy_s) begin
                            if (rd_q && !rec_q && (step_q == RD_READ_STEP)) begin
                                rsp_rdat_q <= mst_rdat_i;
                            end else begin
                                rsp_rdat_q <= rsp_rdat_q;
                            end
                            if (rec_q || last_q) begin
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= err_q;
                                state_q     <= SEQ_DONE;
                            end else begin
                                step_q    <= step_d;
                                last_q    <= rom_last_s;
                                mst_cmd_q <= rom_cmd_s;
                                mst_dat_q <= rom_dat_s;
                                mst_ws_q  <= 1'b1;
                                state_q   <= SEQ_ISSUE;
                            end
                        end else if (cnt_q != '1) begin
                            cnt_q <= cnt_q + CW'(1);
                        end else begin
                            cnt_q <= cnt_q;
                        end
                    end
                    SEQ_CLR: begin
                        // CLRS needs no wait; the recovery STOP follows at once.
                        mst_cmd_q <= C_STOP;
                        mst_dat_q <= 8'h00;
                        mst_ws_q  <= 1'b1;
                        state_q   <= SEQ_ISSUE;
                    end
                    SEQ_DONE: begin
                        req_ready_q <= 1'b1;
                        state_q     <= SEQ_IDLE;
                    end
                    default: begin
                        state_q <= SEQ_IDLE;
                    end
                endcase
            end
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdat_o  = rsp_rdat_q;
    assign mst_cmd_o   = mst_cmd_q;
    assign mst_dat_o   = mst_dat_q;
    assign mst_ws_o    = mst_ws_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer
//   Randomized self-checking bench: a behavioural i2c_master stand-in answers
//   each strobe with BSY/ERR patterns (normal, error, never-busy, stuck-busy),
//   and a transaction-level model predicts the strobed command list, rsp_err
//   and rsp_rdat for each request.
module tb_i2c_reg_sequencer;
    import i2c_reg_sequencer_pkg::*;

    localparam int RISE_TMO = 16;
    localparam int BUSY_TMO = 40;
    localparam int M_NORM = 0, M_ERR = 1, M_NEVER = 2, M_HANG = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid, req_ready_o, req_rd;
    logic [6:0]      req_dev;
    logic [7:0]      req_reg, req_wdat;
    logic            rsp_valid_o, rsp_err_o;
    logic [7:0]      rsp_rdat_o, mst_dat_o, mst_rdat;
    logic [C_SZ-1:0] mst_cmd_o;
    logic            mst_ws_o;
    logic [S_SZ-1:0] mst_stat;

    always #5 clk = ~clk;

    i2c_reg_sequencer #(.RISE_TMO(RISE_TMO), .BUSY_TMO(BUSY_TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_rd_i(req_rd),
        .req_dev_i(req_dev), .req_reg_i(req_reg), .req_wdat_i(req_wdat),
        .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_rdat_o(rsp_rdat_o),
        .mst_cmd_o(mst_cmd_o), .mst_dat_o(mst_dat_o), .mst_ws_o(mst_ws_o),
        .mst_stat_i(mst_stat), .mst_rdat_i(mst_rdat)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- master stand-in ----------------
    int              mode = M_NORM, err_idx = 0, err_kind = 0;
    int              m_dly, m_len, m_ph, m_idx;
    logic            m_err;
    logic [C_SZ-1:0] m_cmd;
    logic [7:0]      m_rval, m_last_rdat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_stat    <= '0;
            mst_rdat    <= 8'h00;
            m_ph        <= 0;
            m_idx       <= 0;
            m_dly       <= 0;
            m_len       <= 0;
            m_err       <= 1'b0;
            m_cmd       <= '0;
            m_rval      <= 8'h00;
            m_last_rdat <= 8'h00;
        end else begin
            mst_rdat <= 8'($urandom);
            if (rsp_valid_o) m_idx <= 0;
            if (mst_ws_o) begin
                m_idx    <= m_idx + 1;
                mst_stat <= '0;
                m_cmd    <= mst_cmd_o;
                m_rval   <= 8'($urandom);
                if (mst_cmd_o == C_CLRS || mode == M_NEVER) begin
                    m_ph <= 0;
                end else begin
                    m_dly <= $urandom_range(0, 5);
                    m_len <= $urandom_range(1, 6);
                    m_err <= (mode == M_ERR) && (m_idx == err_idx);
                    m_ph  <= 1;
                end
            end else if (m_ph == 1) begin
                if (m_dly == 0) begin
                    if (m_err && err_kind == 0) begin
                        mst_stat[SB_ERR] <= 1'b1;
                        m_ph <= 0;
                    end else begin
                        mst_stat[SB_BSY] <= 1'b1;
                        m_ph <= 2;
                    end
                end else begin
                    m_dly <= m_dly - 1;
                end
            end else if (m_ph == 2 && mode != M_HANG) begin
                if (m_len == 0) begin
                    mst_stat[SB_BSY] <= 1'b0;
                    if (m_err) mst_stat[SB_ERR] <= 1'b1;
                    if (m_cmd == (C_READ | C_NACK)) begin
                        mst_rdat <= m_rval;
                        if (!m_err) m_last_rdat <= m_rval;
                    end
                    m_ph <= 0;
                end else begin
                    m_len <= m_len - 1;
                end
            end
        end
    end

    // ---------------- strobe logger ----------------
    int                cyc = 0;
    logic [C_SZ+7:0]   ws_log[$];
    int                ws_time[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mst_ws_o === 1'b1) begin
            ws_log.push_back({mst_cmd_o, mst_dat_o});
            ws_time.push_back(cyc);
        end
    end

    // ---------------- reference model ----------------
    logic [C_SZ+7:0] e_q[$];
    bit              dc_q[$];

    function automatic void build_exp(input bit rd, input logic [6:0] dev,
                                      input logic [7:0] rg, input logic [7:0] wd);
        logic [C_SZ+7:0] full[$];
        bit              fdc[$];
        int              keep;
        e_q.delete();
        dc_q.delete();
        full.push_back({C_STRT | C_WRTE, dev, 1'b0}); fdc.push_back(1'b0);
        full.push_back({C_WRTE, rg});                 fdc.push_back(1'b0);
        if (rd) begin
            full.push_back({C_STRT | C_WRTE, dev, 1'b1}); fdc.push_back(1'b0);
            full.push_back({C_READ | C_NACK, 8'h00});     fdc.push_back(1'b1);
            full.push_back({C_STOP, 8'h00});              fdc.push_back(1'b1);
        end else begin
            full.push_back({C_WRTE | C_STOP, wd});        fdc.push_back(1'b0);
        end
        keep = (mode == M_NORM) ? full.size() : (mode == M_ERR) ? err_idx + 1 : 1;
        for (int i = 0; i < keep; i++) begin
            e_q.push_back(full[i]);
            dc_q.push_back(fdc[i]);
        end
        if (mode != M_NORM) begin
            e_q.push_back({C_CLRS, 8'h00}); dc_q.push_back(1'b1);
            e_q.push_back({C_STOP, 8'h00}); dc_q.push_back(1'b1);
        end
    endfunction

    task automatic send(input bit rd, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
        int k;
        req_rd = rd; req_dev = dev; req_reg = rg; req_wdat = wd;
        req_valid = 1'b1;
        k = 0;
        while (req_ready_o !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (req_ready_o !== 1'b1) check_val("accept_wait", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic collect(input bit rd, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
        int k, n, gap;
        build_exp(rd, dev, rg, wd);
        k = 0;
        while (rsp_valid_o !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (rsp_valid_o !== 1'b1) begin
            check_val("rsp_wait", 32'd0, 32'd1);
            ws_log.delete(); ws_time.delete();
            return;
        end
        check_val("ws_count", 32'(ws_log.size()), 32'(e_q.size()));
        n = (ws_log.size() < e_q.size()) ? ws_log.size() : e_q.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("cmd%0d", i), 32'(ws_log[i][C_SZ+7:8]), 32'(e_q[i][C_SZ+7:8]));
            if (!dc_q[i]) check_val($sformatf("dat%0d", i), 32'(ws_log[i][7:0]), 32'(e_q[i][7:0]));
        end
        check_val("rsp_err", 32'(rsp_err_o), 32'(mode != M_NORM));
        check_val("rsp_rdat", 32'(rsp_rdat_o), 32'(m_last_rdat));
        check_val("ready_in_done", 32'(req_ready_o), 32'd0);
        if ((mode == M_NEVER || mode == M_HANG) && ws_time.size() >= 2) begin
            gap = ws_time[1] - ws_time[0];
            if (mode == M_NEVER)
                check_val("rise_tmo_gap", 32'((gap >= RISE_TMO) && (gap <= RISE_TMO + 2)), 32'd1);
            else
                check_val("busy_tmo_gap", 32'((gap >= BUSY_TMO + 1) && (gap <= BUSY_TMO + 10)), 32'd1);
        end
        ws_log.delete(); ws_time.delete();
        @(negedge clk);
        check_val("rsp_pulse", 32'(rsp_valid_o), 32'd0);
        check_val("ready_after", 32'(req_ready_o), 32'd1);
    endtask

    task automatic txn(input bit rd, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
        send(rd, dev, rg, wd);
        req_valid = 1'b0;
        collect(rd, dev, rg, wd);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, 32'(req_ready_o), 32'd0);
        check_val({tag, "_rsp"},   32'({rsp_valid_o, rsp_err_o, rsp_rdat_o}), 32'd0);
        check_val({tag, "_mst"},   32'({mst_ws_o, mst_cmd_o, mst_dat_o}), 32'd0);
    endtask

    logic       r_rd, b_rd;
    logic [6:0] r_dev, b_dev;
    logic [7:0] r_reg, r_wd, b_reg, b_wd;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_rd = 1'b0;
        req_dev = 7'h00; req_reg = 8'h00; req_wdat = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_val("ready_idle", 32'(req_ready_o), 32'd1);

        // Directed cases from the block's usage examples.
        mode = M_NORM; txn(1'b0, 7'h3b, 8'h10, 8'ha5);
        mode = M_NORM; txn(1'b1, 7'h3b, 8'h10, 8'h00);
        mode = M_ERR; err_idx = 0; err_kind = 0; txn(1'b0, 7'h12, 8'h10, 8'h33);
        mode = M_NEVER; txn(1'b0, 7'h3b, 8'h20, 8'h44);
        mode = M_HANG;  txn(1'b1, 7'h3b, 8'h21, 8'h00);

        // Randomized transactions.
        for (int t = 0; t < 24; t++) begin
            r_rd  = 1'($urandom);
            r_dev = 7'($urandom);
            r_reg = 8'($urandom);
            r_wd  = 8'($urandom);
            if ($urandom_range(0, 9) < 6) begin
                mode = M_NORM;
            end else begin
                mode     = M_ERR;
                err_idx  = $urandom_range(0, r_rd ? 4 : 2);
                err_kind = $urandom_range(0, 1);
            end
            txn(r_rd, r_dev, r_reg, r_wd);
        end

        // Back-to-back: valid stays high, second request must wait for the first.
        mode = M_NORM;
        r_rd = 1'b1; r_dev = 7'h3b; r_reg = 8'h5a; r_wd = 8'h00;
        b_rd = 1'b0; b_dev = 7'h21; b_reg = 8'h07; b_wd = 8'hc3;
        send(r_rd, r_dev, r_reg, r_wd);
        req_rd = b_rd; req_dev = b_dev; req_reg = b_reg; req_wdat = b_wd;
        collect(r_rd, r_dev, r_reg, r_wd);
        txn(b_rd, b_dev, b_reg, b_wd);

        // Asynchronous reset during the READ step.
        mode = M_NORM;
        send(1'b1, 7'h3b, 8'h10, 8'h00);
        req_valid = 1'b0;
        for (int k = 0; k < 500 && ws_log.size() < 4; k++) @(negedge clk);
        check_val("reached_read_step", 32'(ws_log.size() >= 4), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        ws_log.delete(); ws_time.delete();
        @(negedge clk);
        txn(1'b0, 7'h3b, 8'h11, 8'h5c);
        txn(1'b1, 7'h3b, 8'h11, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
